// File: rtl/uart_pkg.sv
// Shared types and helpers for the FIFO-buffered UART transceiver.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_HOLD
    } rx_state_t;

    // Bit period in clock cycles, rounded to nearest.
    function automatic int div_calc(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Parity bit for a data word; unused upper bits must be zero.
    function automatic logic calc_parity(input logic [7:0] data, input parity_t mode);
        return (mode == ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_fifo_xcvr_sync_fifo.sv
// Synchronous FIFO with occupancy output. Read data comes from storage
// registers, so a word written on one edge is visible only after that edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == LW'(DEPTH));
    assign level   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer/occupancy next state; a write to a full FIFO lands only if a read frees a slot.
    always_comb begin
        do_wr    = wr_en && (!full || rd_en);
        do_rd    = rd_en && !empty;
        wr_ptr_d = wr_ptr_q + AW'(do_wr);
        rd_ptr_d = rd_ptr_q + AW'(do_rd);
        count_d  = count_q + LW'(do_wr) - LW'(do_rd);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, written only on an accepted push.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_fifo_xcvr.sv
// FIFO-buffered UART transceiver: AXI-Stream byte streams on the fabric side,
// serial rxd/txd on the pad side, single clock domain.
module uart_fifo_xcvr
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    input  logic [DATA_BITS-1:0]        tx_tdata,
    input  logic                        tx_tvalid,
    output logic                        tx_tready,
    output logic [DATA_BITS-1:0]        rx_tdata,
    output logic [1:0]                  rx_tuser,
    output logic                        rx_tvalid,
    input  logic                        rx_tready,
    output logic                        rx_overrun,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    input  logic                        uart_rxd,
    output logic                        uart_txd
);

    localparam int      DIV      = div_calc(CLK_HZ, BAUD);
    localparam int      HALF     = DIV / 2;
    localparam int      CW       = $clog2(DIV);
    localparam int      FW       = DATA_BITS + 2;
    localparam parity_t PAR_MODE = parity_t'(2'(PARITY));
    localparam bit      HAS_PAR  = (PARITY != 0);

    // FIFO side signals
    logic [DATA_BITS-1:0] tx_fifo_dout;
    logic                 tx_empty, tx_full, tx_push, tx_pop;
    logic [FW-1:0]        rx_fifo_dout;
    logic                 rx_empty, rx_full, rx_pop;

    // TX state
    tx_state_t            tx_state_q, tx_state_d;
    logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [3:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 txd_q, txd_d;
    logic                 tx_tick;

    // RX state
    rx_state_t            rx_state_q, rx_state_d;
    logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [3:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_perr_q, rx_perr_d;
    logic                 rx_push_q, rx_push_d;
    logic [FW-1:0]        rx_wdata_q, rx_wdata_d;
    logic                 rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic                 rx_tick, rx_fall;

    assign tx_tready  = !tx_full && axi_aresetn;
    assign tx_push    = tx_tvalid && tx_tready;
    assign rx_tvalid  = !rx_empty;
    assign rx_pop     = rx_tready && !rx_empty;
    assign rx_tdata   = rx_fifo_dout[DATA_BITS-1:0];
    assign rx_tuser   = rx_fifo_dout[FW-1:DATA_BITS];
    assign rx_overrun = rx_push_q && rx_full && !rx_pop;
    assign uart_txd   = txd_q;

    sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .wr_en   (tx_push),
        .wr_data (tx_tdata),
        .rd_en   (tx_pop),
        .rd_data (tx_fifo_dout),
        .empty   (tx_empty),
        .full    (tx_full),
        .level   (tx_level)
    );

    sync_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .wr_en   (rx_push_q),
        .wr_data (rx_wdata_q),
        .rd_en   (rx_pop),
        .rd_data (rx_fifo_dout),
        .empty   (rx_empty),
        .full    (rx_full),
        .level   (rx_level)
    );

    // TX next state: pop on leaving IDLE or at the end of STOP so frames run back-to-back.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        tx_tick    = (tx_cnt_q == CW'(DIV - 1));
        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_tick ? '0 : tx_cnt_q + CW'(1);
        end
        case (tx_state_q)
            TX_IDLE: begin
                tx_cnt_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_d = tx_fifo_dout;
                    tx_par_d   = calc_parity(8'(tx_fifo_dout), PAR_MODE);
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift_d = tx_shift_q >> 1;
                    if (tx_bit_q == 4'(DATA_BITS - 1)) begin
                        tx_bit_d   = '0;
                        tx_state_d = HAS_PAR ? TX_PARITY : TX_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_bit_d   = '0;
                    tx_state_d = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    if (tx_bit_q == 4'(STOP_BITS - 1)) begin
                        tx_bit_d = '0;
                        if (!tx_empty) begin
                            tx_pop     = 1'b1;
                            tx_shift_d = tx_fifo_dout;
                            tx_par_d   = calc_parity(8'(tx_fifo_dout), PAR_MODE);
                            tx_state_d = TX_START;
                        end else begin
                            tx_state_d = TX_IDLE;
                        end
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Line level registered from the current state, giving a glitch-free txd one cycle behind the FSM.
    always_comb begin
        txd_d = 1'b1;
        case (tx_state_q)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = tx_shift_q[0];
            TX_PARITY: txd_d = tx_par_q;
            default:   txd_d = 1'b1;
        endcase
    end

    // TX control registers.
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            txd_q      <= txd_d;
        end
    end

    // TX datapath registers.
    always_ff @(posedge axi_aclk) begin
        tx_shift_q <= tx_shift_d;
        tx_par_q   <= tx_par_d;
    end

    // RX next state: half-bit wait into START, then one sample per bit period at mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_perr_d  = rx_perr_q;
        rx_push_d  = 1'b0;
        rx_wdata_d = rx_wdata_q;
        rx_fall    = rxd_prev_q && !rxd_sync_q;
        rx_tick    = (rx_cnt_q == CW'(DIV - 1));
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_fall) begin
                    rx_state_d = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt_q == CW'(HALF - 1)) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_perr_d  = 1'b0;
                    rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + CW'(1);
                end
            end
            RX_DATA: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
                if (rx_tick) begin
                    rx_shift_d = {rxd_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == 4'(DATA_BITS - 1)) begin
                        rx_state_d = HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
                if (rx_tick) begin
                    rx_perr_d  = rxd_sync_q ^ calc_parity(8'(rx_shift_q), PAR_MODE);
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                rx_cnt_d = rx_tick ? '0 : rx_cnt_q + CW'(1);
                if (rx_tick) begin
                    rx_push_d = 1'b1;
                    if (!rxd_sync_q && (rx_shift_q == '0)) begin
                        // Break: report once as a framing error, then wait for the line to recover.
                        rx_wdata_d = {1'b1, 1'b0, {DATA_BITS{1'b0}}};
                        rx_state_d = RX_HOLD;
                    end else begin
                        rx_wdata_d = {!rxd_sync_q, rx_perr_q, rx_shift_q};
                        rx_state_d = RX_IDLE;
                    end
                end
            end
            RX_HOLD: begin
                rx_cnt_d = '0;
                if (rxd_sync_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX control registers and input synchroniser (idles high like the line).
    always_ff @(posedge axi_aclk) begin
        if (!axi_aresetn) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_push_q  <= 1'b0;
            rxd_meta_q <= 1'b1;
            rxd_sync_q <= 1'b1;
            rxd_prev_q <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_push_q  <= rx_push_d;
            rxd_meta_q <= uart_rxd;
            rxd_sync_q <= rxd_meta_q;
            rxd_prev_q <= rxd_sync_q;
        end
    end

    // RX datapath registers.
    always_ff @(posedge axi_aclk) begin
        rx_shift_q <= rx_shift_d;
        rx_perr_q  <= rx_perr_d;
        rx_wdata_q <= rx_wdata_d;
    end

endmodule
